mips789_muldiv: RTL and testbench
=================================

# mips789_muldiv

Iterative multiply/divide sequencer owning the HI/LO register pair of the mips789 core. It accepts MULT/MULTU/DIV/DIVU commands from the execute stage, runs a radix-2 shift-add or restoring-divide loop for WIDTH cycles, and holds `busy` high throughout so the pipeline control FSM keeps its multiply stall state. Results land in HI/LO, which the execute stage reads with MFHI/MFLO and writes directly with MTHI/MTLO.

## Interface
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- WIDTH, 32, operand and HI/LO width.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch the operation selected by `op`; honoured only in IDLE.
- op  in  2  operation: MD_MULT, MD_MULTU, MD_DIV or MD_DIVU.
- a  in  WIDTH  multiplicand or dividend; sampled on the start edge.
- b  in  WIDTH  multiplier or divisor; sampled on the start edge.
- mthi  in  1  load HI from `a`; honoured only in IDLE.
- mtlo  in  1  load LO from `a`; honoured only in IDLE.
- busy  out  1  high in CALC and SIGN.
- done  out  1  one-cycle pulse in SIGN.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: waits for a command.
  - CALC: WIDTH iterations; a 6-bit counter runs 0..WIDTH-1.
  - SIGN: one cycle of sign fix-up and result commit.
- Transitions:
  - IDLE→CALC on `start`.
  - CALC→SIGN when the counter reaches WIDTH-1.
  - SIGN→IDLE unconditionally.
- Start edge:
  - Latch `op`.
  - For signed ops, latch |a| and |b|.
  - Record neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
- Multiply:
  - A 2·WIDTH accumulator performs one shift-add per cycle.
  - In SIGN, negate the 2·WIDTH product if the op is signed and neg_q=1.
  - HI = upper half, LO = lower half.
- Divide:
  - Restoring divide, one quotient bit per cycle.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend: negate the quotient if neg_q, negate the remainder if neg_r.
  - LO = quotient, HI = remainder.
- Divide by zero (b==0, signed or unsigned): LO = all ones, HI = the original unmodified `a`. Still takes the full latency with no early exit.
- Signed edge case: -2^(WIDTH-1)/-1 yields LO = 0x80000000, HI = 0, with wrap and no trap.
- start, mthi and mtlo are ignored while `busy` is high. No queueing, no error flag.
- mthi and mtlo may be asserted together with `start` in IDLE. The MT write commits, then is overwritten by the result at the end of SIGN.
- HI/LO change only on an MT write, on the SIGN exit edge, or on reset.

## Timing
- Reset (asynchronous assert, released with the clock): state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, operand registers 0.
- A start sampled at edge N gives:
  - busy=1 from N+1 through N+WIDTH+1.
  - CALC for WIDTH cycles.
  - SIGN in the cycle after edge N+WIDTH, with done=1 during that cycle.
  - hi/lo valid after edge N+WIDTH+1.
  - A new start is accepted at edge N+WIDTH+2 at the earliest.
- Reset asserted mid-operation aborts immediately: outputs return to their reset values and no partial result is written.
- mthi/mtlo take effect on the next edge, so hi/lo update one cycle after the request.
- `busy` is a registered state decode, combinationally glitch-free, and safe for the control FSM to sample.

## Structure
- mips789_defs.v gains:
  - MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - MD_IDLE, MD_CALC, MD_SIGN state encodings (2 bits).
- Single module, no sub-modules. The shared negate logic (two's-complement of WIDTH and 2·WIDTH) is a local function, not a separate block.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 → after WIDTH+2 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses exactly once; busy high for 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=0x0000000E, hi=0x00000002.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=0x00000005, full latency.
- start and mthi pulsed mid-CALC with a=0x1234 → ignored; the first result is unchanged. mtlo in IDLE with a=0xCAFE → lo=0xCAFE on the next cycle.
- Assert rst at the 10th CALC cycle → busy=0, done=0, hi=lo=0 immediately. After release, a new MULT 6×7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mips789_muldiv_pkg.sv
// Shared definitions for the mips789 multiply/divide sequencer:
// operation codes, sequencer state encodings, counter width and
// small operation-decode helpers.
package mips789_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_SIGN = 2'b10
    } md_state_e;

    localparam int MD_CNT_W = 6;

    // Divide ops have op[1] set.
    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Signed ops have op[0] clear.
    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mips789_muldiv.sv
// mips789_muldiv: iterative multiply/divide unit owning HI/LO.
// One start launches WIDTH cycles of radix-2 shift-add (multiply) or
// restoring divide, then one SIGN cycle that fixes signs and commits.
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous active-low reset
//   start, op  launch MULT/MULTU/DIV/DIVU (IDLE only)
//   a, b       operands, sampled on the start edge
//   mthi, mtlo load HI / LO from a (IDLE only)
//   busy       high in CALC and SIGN
//   done       one-cycle pulse in SIGN
//   hi, lo     HI / LO registers
module mips789_muldiv
    import mips789_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return (~x) + (2*WIDTH)'(1);
    endfunction

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;   // {rem, quo} or product accumulator
    logic [WIDTH-1:0]      opd_q, opd_d;   // multiplicand or divisor
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic                  dz_q, dz_d;
    logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]      a_abs, b_abs;
    logic [WIDTH:0]        mul_sum, div_top, div_diff;
    logic                  div_ok;
    logic [2*WIDTH-1:0]    prod;
    logic [WIDTH-1:0]      quo, rem, res_hi, res_lo;

    assign a_abs = (md_is_signed(op) && a[WIDTH-1]) ? neg_w(a) : a;
    assign b_abs = (md_is_signed(op) && b[WIDTH-1]) ? neg_w(b) : b;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opd_q} : '0);

    // Divide step: trial-subtract the divisor from the left-shifted remainder.
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_top - {1'b0, opd_q};
    assign div_ok   = ~div_diff[WIDTH];

    // Result fix-up. A zero divisor bypasses sign correction so that
    // HI keeps the raw dividend and LO stays all ones.
    always_comb begin
        prod = acc_q;
        if (md_is_signed(op_q) && negq_q) prod = neg_2w(acc_q);
        quo = acc_q[WIDTH-1:0];
        rem = acc_q[2*WIDTH-1:WIDTH];
        if (!dz_q && md_is_signed(op_q)) begin
            if (negq_q) quo = neg_w(acc_q[WIDTH-1:0]);
            if (negr_q) rem = neg_w(acc_q[2*WIDTH-1:WIDTH]);
        end
        if (md_is_div(op_q)) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (mthi) hi_d = a;
                if (mtlo) lo_d = a;
                if (start) begin
                    state_d = MD_CALC;
                    cnt_d   = '0;
                    op_d    = op;
                    negq_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    negr_d  = a[WIDTH-1];
                    dz_d    = md_is_div(op) && (b == '0);
                    if (md_is_div(op)) begin
                        // Zero divisor: run the raw dividend through so it
                        // emerges unmodified in the remainder half.
                        acc_d = {{WIDTH{1'b0}}, (b == '0) ? a : a_abs};
                        opd_d = b_abs;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_abs};
                        opd_d = a_abs;
                    end
                end
            end
            MD_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (md_is_div(op_q)) begin
                    acc_d = {div_ok ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0],
                             acc_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == MD_CNT_W'(WIDTH-1)) begin
                    state_d = MD_SIGN;
                    cnt_d   = '0;
                end
            end
            MD_SIGN: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Pure decodes of the state register.
    assign busy = (state_q != MD_IDLE);
    assign done = (state_q == MD_SIGN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips789_muldiv.sv
// Bench for mips789_muldiv: directed corner cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_mips789_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips789_muldiv #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint          sx, sy, sp;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'b00: begin
                sp = sx * sy;
                return sp;
            end
            2'b01: begin
                up = ux * uy;
                return up;
            end
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input string tag);
        logic [63:0] e;
        int          nb, nd;
        bit          fin;
        e = model(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        nb = 0; nd = 0; fin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            if (disturb && i == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; a = 32'h1234;
            end
            if (disturb && i == 6) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "/finished"}, {31'b0, fin}, 32'd1);
        chk({tag, "/busy_cycles"}, nb, 32'd33);
        chk({tag, "/done_pulses"}, nd, 32'd1);
        chk({tag, "/hi"}, hi, e[63:32]);
        chk({tag, "/lo"}, lo, e[31:0]);
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0;
        #23;
        chk("reset/busy", {31'b0, busy}, 32'd0);
        chk("reset/done", {31'b0, done}, 32'd0);
        chk("reset/hi", hi, 32'd0);
        chk("reset/lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg3x5");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(2'b11, 32'd5, 32'd0, 1'b0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, "div_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_minint");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_neg2");
        run_op(2'b01, 32'd123, 32'd456, 1'b1, "disturbed");

        // MTLO / MTHI in IDLE take effect one edge later.
        e = model(2'b01, 32'd123, 32'd456);
        @(negedge clk);
        mtlo = 1'b1; a = 32'hCAFE;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo/lo", lo, 32'hCAFE);
        chk("mtlo/hi_kept", hi, e[63:32]);
        mthi = 1'b1; a = 32'hBEEF;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi/hi", hi, 32'hBEEF);
        chk("mthi/lo_kept", lo, 32'hCAFE);

        // MTHI together with start: visible first, then overwritten.
        start = 1'b1; mthi = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("mt_start/hi_mt", hi, 32'd3);
        chk("mt_start/busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("mt_start/idle", {31'b0, busy}, 32'd0);
        chk("mt_start/hi", hi, 32'd0);
        chk("mt_start/lo", lo, 32'd12);

        // Reset during the 10th CALC cycle.
        start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort/busy", {31'b0, busy}, 32'd0);
        chk("abort/done", {31'b0, done}, 32'd0);
        chk("abort/hi", hi, 32'd0);
        chk("abort/lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b00, 32'd6, 32'd7, 1'b0, "mult_6x7");

        // Randomized ops with occasional corner operands.
        for (int k = 0; k < 30; k++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = -32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", k, ro));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
